// File: rtl/flash_config_loader.sv
// Fetches a 22-byte network configuration record from the SPI flash reader,
// validates magic/version/checksum and atomically publishes MAC/IP/gateway/netmask.
module flash_config_loader #(
    parameter logic [23:0] CFG_ADDR       = 24'h1F0000,
    parameter bit          AUTO_START     = 1'b1,
    parameter int          TIMEOUT_CYCLES = 200000,
    parameter logic [47:0] DEFAULT_MAC    = 48'h02_00_00_00_00_01,
    parameter logic [31:0] DEFAULT_IP     = 32'hC0A8_0180,
    parameter logic [31:0] DEFAULT_GW     = 32'hC0A8_0101,
    parameter logic [31:0] DEFAULT_MASK   = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        read_strobe,
    output logic [23:0] start_addr,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [47:0] local_mac,
    output logic [31:0] local_ip,
    output logic [31:0] gateway_ip,
    output logic [31:0] subnet_mask,
    output logic        cfg_valid,
    output logic [1:0]  cfg_error,
    output logic        busy
);

    localparam int             TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_FAIL  = 3'd4;

    localparam logic [1:0] ERR_HDR = 2'd1;
    localparam logic [1:0] ERR_SUM = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    logic [2:0]    r_state;
    logic          r_auto;
    logic          r_read_strobe;
    logic          r_s_tready;
    logic          r_busy;
    logic          r_cfg_valid;
    logic [1:0]    r_cfg_error;
    logic [1:0]    r_fail_code;
    logic [4:0]    r_idx;
    logic [TW-1:0] r_tcnt;
    logic [7:0]    r_sum;
    logic [143:0]  r_shadow;
    logic [47:0]   r_mac;
    logic [31:0]   r_ip;
    logic [31:0]   r_gw;
    logic [31:0]   r_mask;

    logic          w_accept;
    logic [7:0]    w_hdr_byte;
    logic          w_hdr_bad;
    logic          w_payload;
    logic          w_tmo;

    always_comb begin
        w_hdr_byte = 8'h01;
        case (r_idx[1:0])
            2'd0:    w_hdr_byte = 8'h5A;
            2'd1:    w_hdr_byte = 8'h75;
            default: w_hdr_byte = 8'h01;
        endcase
    end

    // s_tready is only ever high in FETCH, so the handshake alone qualifies an accept.
    assign w_accept  = s_tvalid && r_s_tready;
    assign w_hdr_bad = (r_idx < 5'd3) && (s_tdata != w_hdr_byte);
    assign w_payload = (r_idx >= 5'd3) && (r_idx <= 5'd20);
    assign w_tmo     = (r_tcnt == TMO_LAST);

    // Payload bytes 3..20 shift in MSB first; after 18 shifts the register
    // holds {mac, ip, gw, mask} in output order.
    // NOTE: the shadow register has no reset; it is only observed after a full
    // record has been shifted in, so its power-up content never escapes.
    always_ff @(posedge clk) begin
        if (w_accept && w_payload) begin
            r_shadow <= {r_shadow[135:0], s_tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_auto        <= AUTO_START;
            r_read_strobe <= 1'b0;
            r_s_tready    <= 1'b0;
            r_busy        <= 1'b0;
            r_cfg_valid   <= 1'b0;
            r_cfg_error   <= 2'd0;
            r_fail_code   <= 2'd0;
            r_idx         <= 5'd0;
            r_tcnt        <= '0;
            r_sum         <= 8'd0;
            r_mac         <= DEFAULT_MAC;
            r_ip          <= DEFAULT_IP;
            r_gw          <= DEFAULT_GW;
            r_mask        <= DEFAULT_MASK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_auto <= 1'b0;
                    if (start || r_auto) begin
                        r_state       <= S_FETCH;
                        r_read_strobe <= 1'b1;
                        r_s_tready    <= 1'b1;
                        r_busy        <= 1'b1;
                        r_cfg_error   <= 2'd0;
                        r_idx         <= 5'd0;
                        r_tcnt        <= '0;
                        r_sum         <= 8'd0;
                    end
                end
                S_FETCH: begin
                    if (w_accept) begin
                        r_tcnt <= '0;
                        r_sum  <= r_sum + s_tdata;
                        r_idx  <= r_idx + 5'd1;
                        // Drop ready on the deciding edge so no further handshake can complete.
                        if (w_hdr_bad) begin
                            r_fail_code <= ERR_HDR;
                            r_state     <= S_FAIL;
                            r_s_tready  <= 1'b0;
                        end else if (r_idx == 5'd21) begin
                            r_state    <= S_CHECK;
                            r_s_tready <= 1'b0;
                        end
                    end else if (w_tmo) begin
                        r_fail_code <= ERR_TMO;
                        r_state     <= S_FAIL;
                        r_s_tready  <= 1'b0;
                    end else if (r_tcnt != '1) begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_CHECK: begin
                    r_read_strobe <= 1'b0;
                    if (r_sum == 8'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_fail_code <= ERR_SUM;
                        r_state     <= S_FAIL;
                    end
                end
                S_DONE: begin
                    r_mac       <= r_shadow[143:96];
                    r_ip        <= r_shadow[95:64];
                    r_gw        <= r_shadow[63:32];
                    r_mask      <= r_shadow[31:0];
                    r_cfg_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                S_FAIL: begin
                    r_read_strobe <= 1'b0;
                    r_s_tready    <= 1'b0;
                    r_busy        <= 1'b0;
                    r_cfg_error   <= r_fail_code;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign read_strobe = r_read_strobe;
    assign start_addr  = CFG_ADDR;
    assign s_tready    = r_s_tready;
    assign local_mac   = r_mac;
    assign local_ip    = r_ip;
    assign gateway_ip  = r_gw;
    assign subnet_mask = r_mask;
    assign cfg_valid   = r_cfg_valid;
    assign cfg_error   = r_cfg_error;
    assign busy        = r_busy;

endmodule

// File: tb/tb_flash_config_loader.sv
// Randomized scoreboard bench for flash_config_loader: a record-level reference
// model predicts each load outcome; a monitor compares it when busy falls.
module tb_flash_config_loader;

    localparam logic [23:0] CFG_ADDR     = 24'h1F0000;
    localparam logic [47:0] DEFAULT_MAC  = 48'h02_00_00_00_00_01;
    localparam logic [31:0] DEFAULT_IP   = 32'hC0A8_0180;
    localparam logic [31:0] DEFAULT_GW   = 32'hC0A8_0101;
    localparam logic [31:0] DEFAULT_MASK = 32'hFFFF_FF00;

    typedef struct packed {
        logic [47:0] mac;
        logic [31:0] ip;
        logic [31:0] gw;
        logic [31:0] mask;
        logic        valid;
        logic [1:0]  err;
        logic [4:0]  nbytes;
        logic [4:0]  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        read_strobe;
    logic [23:0] start_addr;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic [31:0] gateway_ip;
    logic [31:0] subnet_mask;
    logic        cfg_valid;
    logic [1:0]  cfg_error;
    logic        busy;

    int checks = 0;
    int errors = 0;

    exp_t        sb_q[$];
    logic [7:0]  rec [22];
    logic [47:0] m_mac  = DEFAULT_MAC;
    logic [31:0] m_ip   = DEFAULT_IP;
    logic [31:0] m_gw   = DEFAULT_GW;
    logic [31:0] m_mask = DEFAULT_MASK;
    logic        m_valid = 1'b0;

    flash_config_loader #(
        .CFG_ADDR      (CFG_ADDR),
        .AUTO_START    (1'b1),
        .TIMEOUT_CYCLES(16),
        .DEFAULT_MAC   (DEFAULT_MAC),
        .DEFAULT_IP    (DEFAULT_IP),
        .DEFAULT_GW    (DEFAULT_GW),
        .DEFAULT_MASK  (DEFAULT_MASK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .read_strobe(read_strobe),
        .start_addr (start_addr),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .local_mac  (local_mac),
        .local_ip   (local_ip),
        .gateway_ip (gateway_ip),
        .subnet_mask(subnet_mask),
        .cfg_valid  (cfg_valid),
        .cfg_error  (cfg_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic build_rec(input logic [47:0] mac, input logic [31:0] ip,
                             input logic [31:0] gw, input logic [31:0] mask);
        logic [7:0] s;
        rec[0] = 8'h5A;
        rec[1] = 8'h75;
        rec[2] = 8'h01;
        for (int k = 0; k < 6; k++) rec[3 + k]  = mac[47 - 8*k -: 8];
        for (int k = 0; k < 4; k++) rec[9 + k]  = ip[31 - 8*k -: 8];
        for (int k = 0; k < 4; k++) rec[13 + k] = gw[31 - 8*k -: 8];
        for (int k = 0; k < 4; k++) rec[17 + k] = mask[31 - 8*k -: 8];
        s = 8'h00;
        for (int k = 0; k < 21; k++) s = s + rec[k];
        rec[21] = 8'h00 - s;
    endtask

    // Reference model: outcome of a load of rec when the source offers n_offer bytes.
    // lat counts monitor cycles from the last accepted byte to busy going low.
    task automatic expect_load(input int n_offer);
        logic [7:0] hdr [3];
        logic [7:0] s;
        exp_t e;
        hdr[0] = 8'h5A;
        hdr[1] = 8'h75;
        hdr[2] = 8'h01;
        e.err = 2'd0;
        e.nbytes = 5'd22;
        e.lat = 5'd3;
        for (int i = 0; i < 3; i++) begin
            if (e.err == 2'd0 && rec[i] != hdr[i]) begin
                e.err = 2'd1;
                e.nbytes = 5'(i + 1);
                e.lat = 5'd2;
            end
        end
        if (e.err == 2'd0 && n_offer < 22) begin
            e.err = 2'd3;
            e.nbytes = 5'(n_offer);
            e.lat = 5'd18;
        end else if (e.err == 2'd0) begin
            s = 8'h00;
            for (int k = 0; k < 22; k++) s = s + rec[k];
            if (s != 8'h00) begin
                e.err = 2'd2;
            end else begin
                m_mac   = {rec[3], rec[4], rec[5], rec[6], rec[7], rec[8]};
                m_ip    = {rec[9], rec[10], rec[11], rec[12]};
                m_gw    = {rec[13], rec[14], rec[15], rec[16]};
                m_mask  = {rec[17], rec[18], rec[19], rec[20]};
                m_valid = 1'b1;
            end
        end
        e.mac = m_mac;
        e.ip = m_ip;
        e.gw = m_gw;
        e.mask = m_mask;
        e.valid = m_valid;
        sb_q.push_back(e);
    endtask

    // Offers rec[0..] one byte at a time; stops after n_offer accepts or when
    // the DUT stops accepting (abort). Called and returns at posedge + 1.
    task automatic send(input int n_offer, input int max_gap);
        int sent = 0;
        int w;
        for (int i = 0; i < 22; i++) begin
            if (sent >= n_offer) break;
            repeat ($urandom_range(0, max_gap)) begin
                s_tvalid = 1'b0;
                s_tdata  = 8'($urandom);
                @(posedge clk); #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = rec[i];
            w = 0;
            forever begin
                @(negedge clk);
                if (s_tready) begin
                    @(posedge clk); #1;
                    sent++;
                    break;
                end
                @(posedge clk); #1;
                w++;
                if (w > 30) begin
                    s_tvalid = 1'b0;
                    return;
                end
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        @(posedge clk); #1;
        while (sb_q.size() != 0 && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        check("scoreboard_drain", 64'(sb_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_load(input int n_offer, input int max_gap);
        expect_load(n_offer);
        pulse_start();
        send(n_offer, max_gap);
        wait_done();
    endtask

    task automatic rand_rec();
        build_rec({$urandom, $urandom}, $urandom, $urandom, $urandom);
    endtask

    // Monitor: counts handshakes, and on every busy fall pops and compares.
    int   cyc = 0;
    int   last_acc = 0;
    int   nacc = 0;
    int   chk_rs_at = -1;
    logic prev_busy = 1'b0;
    logic [176:0] prev_cfg = '0;

    always @(negedge clk) begin
        exp_t e;
        logic fall;
        cyc++;
        if (rst) begin
            prev_busy = 1'b0;
            nacc = 0;
            chk_rs_at = -1;
            prev_cfg = {local_mac, local_ip, gateway_ip, subnet_mask, cfg_valid};
        end else begin
            fall = prev_busy && !busy;
            if (busy && !prev_busy) nacc = 0;
            if (cyc == chk_rs_at) check("read_strobe_after_byte21", 64'(read_strobe), 64'd0);
            if ({local_mac, local_ip, gateway_ip, subnet_mask, cfg_valid} != prev_cfg && !fall)
                check("cfg_changed_outside_commit", 64'd1, 64'd0);
            if (fall) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_load", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("cfg_error",     64'(cfg_error),   64'(e.err));
                    check("cfg_valid",     64'(cfg_valid),   64'(e.valid));
                    check("local_mac",     64'(local_mac),   64'(e.mac));
                    check("local_ip",      64'(local_ip),    64'(e.ip));
                    check("gateway_ip",    64'(gateway_ip),  64'(e.gw));
                    check("subnet_mask",   64'(subnet_mask), 64'(e.mask));
                    check("bytes_accepted", 64'(nacc),       64'(e.nbytes));
                    check("outcome_latency", 64'(cyc - last_acc), 64'(e.lat));
                    check("read_strobe_idle", 64'(read_strobe), 64'd0);
                    check("s_tready_idle",    64'(s_tready),    64'd0);
                end
            end
            if (s_tvalid && s_tready) begin
                nacc++;
                last_acc = cyc;
                if (nacc == 22) chk_rs_at = cyc + 2;
            end
            prev_busy = busy;
            prev_cfg = {local_mac, local_ip, gateway_ip, subnet_mask, cfg_valid};
        end
    end

    initial begin
        int kind;
        int j;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_read_strobe", 64'(read_strobe), 64'd0);
        check("rst_s_tready",    64'(s_tready),    64'd0);
        check("rst_busy",        64'(busy),        64'd0);
        check("rst_cfg_valid",   64'(cfg_valid),   64'd0);
        check("rst_cfg_error",   64'(cfg_error),   64'd0);
        check("rst_local_mac",   64'(local_mac),   64'(DEFAULT_MAC));
        check("rst_local_ip",    64'(local_ip),    64'(DEFAULT_IP));
        check("rst_gateway_ip",  64'(gateway_ip),  64'(DEFAULT_GW));
        check("rst_subnet_mask", 64'(subnet_mask), 64'(DEFAULT_MASK));
        check("start_addr",      64'(start_addr),  64'(CFG_ADDR));
        @(posedge clk); #1;

        // Auto-start load with a corrupted checksum: defaults must survive.
        build_rec(48'h021122334455, 32'hC0A80132, 32'hC0A80101, 32'hFFFFFF00);
        rec[21] = rec[21] + 8'd1;
        expect_load(22);
        rst = 1'b0;
        send(22, 0);
        wait_done();

        // Bad first magic byte.
        build_rec(48'h021122334455, 32'hC0A80132, 32'hC0A80101, 32'hFFFFFF00);
        rec[0] = 8'hFF;
        run_load(22, 0);

        // Source stalls after byte 5.
        build_rec(48'h021122334455, 32'hC0A80132, 32'hC0A80101, 32'hFFFFFF00);
        run_load(6, 0);

        // Reference record commits.
        build_rec(48'h021122334455, 32'hC0A80132, 32'hC0A80101, 32'hFFFFFF00);
        run_load(22, 0);
        check("plan_mac", 64'(local_mac), 64'h021122334455);
        check("plan_ip",  64'(local_ip),  64'hC0A80132);

        // Random gaps with a stray start mid-fetch.
        rand_rec();
        expect_load(22);
        pulse_start();
        fork
            send(22, 10);
            begin
                repeat ($urandom_range(5, 15)) @(posedge clk);
                #1;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        wait_done();

        // Randomized mix of valid, bad checksum and bad header records.
        for (int it = 0; it < 8; it++) begin
            rand_rec();
            kind = $urandom_range(0, 2);
            if (kind == 1) begin
                rec[21] = rec[21] + 8'($urandom_range(1, 255));
            end else if (kind == 2) begin
                j = $urandom_range(0, 2);
                rec[j] = rec[j] ^ 8'($urandom_range(1, 255));
            end
            run_load(22, 3);
        end

        // Successful load, then reset in the middle of the next one.
        rand_rec();
        run_load(22, 1);
        rand_rec();
        expect_load(22);
        pulse_start();
        send(10, 1);
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_cfg_valid",   64'(cfg_valid),   64'd0);
        check("midrst_read_strobe", 64'(read_strobe), 64'd0);
        check("midrst_busy",        64'(busy),        64'd0);
        check("midrst_local_mac",   64'(local_mac),   64'(DEFAULT_MAC));
        check("midrst_local_ip",    64'(local_ip),    64'(DEFAULT_IP));
        check("midrst_gateway_ip",  64'(gateway_ip),  64'(DEFAULT_GW));
        check("midrst_subnet_mask", 64'(subnet_mask), 64'(DEFAULT_MASK));
        m_mac   = DEFAULT_MAC;
        m_ip    = DEFAULT_IP;
        m_gw    = DEFAULT_GW;
        m_mask  = DEFAULT_MASK;
        m_valid = 1'b0;

        // Auto-start after reset release loads a fresh record.
        @(posedge clk); #1;
        rand_rec();
        expect_load(22);
        rst = 1'b0;
        send(22, 2);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_config_loader.md
Name: flash_config_loader

Overview:
- Downstream consumer of the SPI flash reader's byte stream.
- Drives the reader's read_strobe and start_addr, then pulls a fixed 22-byte network configuration record from flash and validates it.
- Publishes MAC/IP/gateway/netmask to the Ethernet/UDP stack, or keeps parameter defaults on any failure.

Parameters:
CFG_ADDR, 24'h1F0000, flash byte address of the config record
AUTO_START, 1, 1 = begin a load in the first cycle after reset release
TIMEOUT_CYCLES, 200000, max clk cycles between accepted bytes before abort (>=2)
DEFAULT_MAC, 48'h02_00_00_00_00_01, MAC used until a valid record commits
DEFAULT_IP, 32'hC0A8_0180, default local IP (192.168.1.128)
DEFAULT_GW, 32'hC0A8_0101, default gateway
DEFAULT_MASK, 32'hFFFF_FF00, default netmask

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  single-cycle load request; ignored while busy
read_strobe  out  1  enable to flash reader; held high for the whole fetch
start_addr  out  24  always CFG_ADDR
s_tdata  in  8  byte from flash reader
s_tvalid  in  1  byte valid
s_tready  out  1  byte accept
local_mac  out  48  committed MAC
local_ip  out  32  committed IP
gateway_ip  out  32  committed gateway
subnet_mask  out  32  committed netmask
cfg_valid  out  1  high once a valid record has been committed
cfg_error  out  2  0 none, 1 bad magic/version, 2 bad checksum, 3 timeout
busy  out  1  high while a load is in progress

Behaviour:
- Reset is rst, synchronous, active-high, on clock clk.
- Reset values: read_strobe=0, s_tready=0, busy=0, cfg_valid=0, cfg_error=0, config outputs = DEFAULT_*, byte counter=0, timeout counter=0.
- Record layout, byte index 0..21:
  - 0-1: magic 0x5A, 0x75.
  - 2: version 0x01.
  - 3-8: MAC, MSB first.
  - 9-12: IP, MSB first.
  - 13-16: gateway, MSB first.
  - 17-20: netmask, MSB first.
  - 21: checksum. The 8-bit sum of bytes 0..21, modulo 256, must equal 0x00.
- FSM states: IDLE, FETCH, CHECK, DONE, FAIL.
- IDLE:
  - start=1, or the first cycle after reset when AUTO_START=1 -> FETCH.
  - On the same edge: read_strobe<=1, s_tready<=1, busy<=1, cfg_error<=0, counters cleared, running sum cleared.
- FETCH:
  - A byte is accepted on any edge where s_tvalid && s_tready.
  - On accept: byte goes into the shadow register slot for the current index; sum<=sum+byte; index increments; timeout counter clears.
  - On an edge without accept, the timeout counter increments.
  - Index 0..2 mismatch against the expected magic/version -> FAIL with code 1, checked on the accept edge.
  - Accept of index 21 -> CHECK, s_tready<=0.
  - Timeout counter reaching TIMEOUT_CYCLES-1 without accept -> FAIL with code 3.
- CHECK (1 cycle): read_strobe<=0. Final sum==0 -> DONE, else FAIL with code 2.
- DONE (1 cycle): shadow registers copied to all four config outputs atomically; cfg_valid<=1; busy<=0; -> IDLE.
- FAIL (1 cycle): read_strobe<=0, s_tready<=0, busy<=0, cfg_error latched; config outputs and cfg_valid unchanged (previous commit or defaults); -> IDLE.
- Config outputs never change except in DONE or on reset. Partial records are never visible.
- start while busy: ignored. start in the same cycle as a DONE/FAIL exit: ignored; the next start is honoured from IDLE.
- Dropping read_strobe resets the flash reader. It is deasserted within 1 cycle of CHECK/FAIL entry. No byte is accepted after index 21 or after an abort.
- s_tvalid gaps of any length below TIMEOUT_CYCLES are legal. Data in those gaps is ignored.
- Reset mid-fetch: all state returns to reset values in the same edge; read_strobe falls; cfg_valid clears.
- Arithmetic: sum is an 8-bit wrapping add. Byte counter is 5 bits. Timeout counter is clog2(TIMEOUT_CYCLES) bits and saturates.

Test Plan:
- AUTO_START=1, source supplies 5A 75 01 02 11 22 33 44 55 C0 A8 01 32 C0 A8 01 01 FF FF FF 00 + correct checksum -> local_mac=48'h021122334455, local_ip=32'hC0A80132, gateway_ip=32'hC0A80101, subnet_mask=32'hFFFFFF00, cfg_valid=1, cfg_error=0, read_strobe low 1 cycle after byte 21.
- Same record with the checksum byte incremented by 1 -> cfg_error=2, outputs remain DEFAULT_*, cfg_valid=0, exactly 22 bytes accepted.
- First byte 0xFF -> cfg_error=1 on that accept edge + 1 cycle, read_strobe low, only 1 byte accepted.
- TIMEOUT_CYCLES=16, source stalls after byte 5 -> FAIL at 16 idle cycles, cfg_error=3, busy=0; a later start with a valid record -> cfg_error=0, cfg_valid=1.
- Valid record with random s_tvalid gaps (0-10 cycles) plus a start pulse mid-fetch -> one load only, correct commit, start ignored.
- rst asserted at byte 10 of a second load after a successful one -> cfg_valid=0, outputs = DEFAULT_*, read_strobe=0 the next cycle.
